// File: rtl/branch_predict_unit.sv
// branch_predict_unit
//   Dynamic branch predictor and mispredict controller for a 5-stage RV32I pipe.
//   IF side : direct-mapped BTB with 2-bit saturating counters gives a
//             zero-latency prediction for PCF.
//   EX side : compares the prediction carried down the pipe against the
//             resolved outcome, raises a redirect on mismatch, trains the
//             tables and keeps branch / mispredict event counters.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   PCF                      fetch PC
//   PredTakenF, PredNextPCF  prediction for PCF
//   PCE, BranchTypeE,        EX-stage instruction PC, branch type,
//   BranchE, BranchTargetE   resolved direction and target
//   PredTakenE, PredTargetE  prediction that travelled with the EX instruction
//   StallE                   EX stalled; instruction not yet committed
//   MispredictE, RedirectPCE flush request and corrected fetch PC
//   BranchCnt, MissCnt       performance counters (wrap at 2^32)
module branch_predict_unit #(
  parameter int ENTRIES = 16,
  parameter int INDEX_W = $clog2(ENTRIES)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PCF,
  output logic        PredTakenF,
  output logic [31:0] PredNextPCF,
  input  logic [31:0] PCE,
  input  logic [2:0]  BranchTypeE,
  input  logic        BranchE,
  input  logic [31:0] BranchTargetE,
  input  logic        PredTakenE,
  input  logic [31:0] PredTargetE,
  input  logic        StallE,
  output logic        MispredictE,
  output logic [31:0] RedirectPCE,
  output logic [31:0] BranchCnt,
  output logic [31:0] MissCnt
);

  localparam int TAG_W = 30 - INDEX_W;

  // Control state (reset) and data state (not reset; guarded by valid).
  logic [ENTRIES-1:0]       valid;
  logic [ENTRIES-1:0][1:0]  cnt;
  logic [TAG_W-1:0]         tag    [ENTRIES];
  logic [31:0]              target [ENTRIES];

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  logic [INDEX_W-1:0] idx_f, idx_e;
  logic [TAG_W-1:0]   tag_f, tag_e;
  logic               hit_f, hit_e;
  logic               ev_q;
  logic               stale_q;
  logic               unused_pc_bits;

  // Byte-offset bits never take part in indexing or tagging.
  assign unused_pc_bits = ^{PCF[1:0], PCE[1:0]};

  // IF lookup: reads registered state only, so a same-cycle update is not
  // visible until the following cycle.
  assign idx_f       = PCF[INDEX_W+1:2];
  assign tag_f       = PCF[31:INDEX_W+2];
  assign hit_f       = valid[idx_f] && (tag[idx_f] == tag_f);
  assign PredTakenF  = hit_f && cnt[idx_f][1];
  assign PredNextPCF = PredTakenF ? target[idx_f] : PCF + 32'd4;

  // EX resolution
  assign idx_e   = PCE[INDEX_W+1:2];
  assign tag_e   = PCE[31:INDEX_W+2];
  assign hit_e   = valid[idx_e] && (tag[idx_e] == tag_e);
  assign ev_q    = (BranchTypeE != 3'd0) && !StallE && !rst;
  // A non-branch that was predicted taken came from a stale or aliased entry.
  assign stale_q = (BranchTypeE == 3'd0) && PredTakenE && !StallE && !rst;

  always_comb begin
    MispredictE = 1'b0;
    if (ev_q)
      MispredictE = (BranchE != PredTakenE) ||
                    (BranchE && (PredTargetE != BranchTargetE));
    else if (stale_q)
      MispredictE = 1'b1;
  end

  assign RedirectPCE = BranchE ? BranchTargetE : PCE + 32'd4;

  // Table training and event counters
  always_ff @(posedge clk) begin
    if (rst) begin
      valid     <= '0;
      cnt       <= {ENTRIES{2'b01}};
      BranchCnt <= '0;
      MissCnt   <= '0;
    end else begin
      if (ev_q) begin
        BranchCnt <= BranchCnt + 32'd1;
        if (hit_e) begin
          cnt[idx_e] <= BranchE ? sat_inc(cnt[idx_e]) : sat_dec(cnt[idx_e]);
        end else if (BranchE) begin
          // Allocation simply overwrites whatever owned this index.
          valid[idx_e] <= 1'b1;
          cnt[idx_e]   <= 2'b10;
        end
      end else if (stale_q && hit_e) begin
        valid[idx_e] <= 1'b0;
      end
      if (MispredictE)
        MissCnt <= MissCnt + 32'd1;
    end
  end

  // Tag/target payload; on a hit the tag rewrite is a no-op.
  always_ff @(posedge clk) begin
    if (ev_q && BranchE) begin
      target[idx_e] <= BranchTargetE;
      tag[idx_e]    <= tag_e;
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
module tb_branch_predict_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PCF, PCE, BranchTargetE, PredTargetE;
  logic [2:0]  BranchTypeE;
  logic        BranchE, PredTakenE, StallE;
  logic        PredTakenF, MispredictE;
  logic [31:0] PredNextPCF, RedirectPCE, BranchCnt, MissCnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_predict_unit #(.ENTRIES(16)) dut (
    .clk(clk), .rst(rst), .PCF(PCF), .PredTakenF(PredTakenF),
    .PredNextPCF(PredNextPCF), .PCE(PCE), .BranchTypeE(BranchTypeE),
    .BranchE(BranchE), .BranchTargetE(BranchTargetE), .PredTakenE(PredTakenE),
    .PredTargetE(PredTargetE), .StallE(StallE), .MispredictE(MispredictE),
    .RedirectPCE(RedirectPCE), .BranchCnt(BranchCnt), .MissCnt(MissCnt)
  );

  // Reference model: one record per table slot, plain integers.
  bit          m_valid  [16];
  logic [31:0] m_tag    [16];
  logic [31:0] m_target [16];
  int          m_cnt    [16];
  logic [31:0] m_bcnt, m_mcnt;

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc / 32'd4) % 32'd16);
  endfunction

  function automatic logic [31:0] m_tagof(input logic [31:0] pc);
    return pc / 32'd64;
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[m_idx(pc)] && (m_tag[m_idx(pc)] == m_tagof(pc));
  endfunction

  function automatic bit m_taken(input logic [31:0] pc);
    return m_hit(pc) && (m_cnt[m_idx(pc)] >= 2);
  endfunction

  function automatic logic [31:0] m_next(input logic [31:0] pc);
    return m_taken(pc) ? m_target[m_idx(pc)] : pc + 32'd4;
  endfunction

  function automatic bit m_mispredict();
    if (rst || StallE) return 1'b0;
    if (BranchTypeE != 3'd0)
      return (BranchE != PredTakenE) || (BranchE && (PredTargetE != BranchTargetE));
    return PredTakenE;
  endfunction

  // Advance the model with the inputs present at the coming edge, then clock.
  task automatic tick();
    bit mp;
    int i;
    if (rst) begin
      for (int k = 0; k < 16; k++) begin
        m_valid[k] = 1'b0;
        m_cnt[k]   = 1;
      end
      m_bcnt = 32'd0;
      m_mcnt = 32'd0;
    end else begin
      mp = m_mispredict();
      i  = m_idx(PCE);
      if (BranchTypeE != 3'd0 && !StallE) begin
        m_bcnt = m_bcnt + 32'd1;
        if (m_hit(PCE)) begin
          if (BranchE) begin
            m_cnt[i]    = (m_cnt[i] == 3) ? 3 : m_cnt[i] + 1;
            m_target[i] = BranchTargetE;
          end else begin
            m_cnt[i] = (m_cnt[i] == 0) ? 0 : m_cnt[i] - 1;
          end
        end else if (BranchE) begin
          m_valid[i]  = 1'b1;
          m_tag[i]    = m_tagof(PCE);
          m_target[i] = BranchTargetE;
          m_cnt[i]    = 2;
        end
      end else if (BranchTypeE == 3'd0 && PredTakenE && !StallE && m_hit(PCE)) begin
        m_valid[i] = 1'b0;
      end
      if (mp) m_mcnt = m_mcnt + 32'd1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ex();
    PCE = 32'h0; BranchTypeE = 3'd0; BranchE = 1'b0; BranchTargetE = 32'h0;
    PredTakenE = 1'b0; PredTargetE = 32'h0; StallE = 1'b0;
  endtask

  // Present a resolved branch in EX carrying the prediction it was fetched with.
  task automatic set_ex(input logic [31:0] pc, input logic [2:0] typ,
                        input logic taken, input logic [31:0] tgt);
    PCE = pc; BranchTypeE = typ; BranchE = taken; BranchTargetE = tgt;
    PredTakenE = m_taken(pc); PredTargetE = m_next(pc); StallE = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle_ex(); PCF = 32'h100;
    PredTakenE = 1'b1;
    #1;
    checks++; if (MispredictE !== 1'b0) begin errors++; $display("FAIL rst_forces_no_mispredict got=%0b exp=0", MispredictE); end
    tick(); tick();
    rst = 1'b0; PredTakenE = 1'b0;
    #1;
    checks++; if (PredTakenF !== 1'b0) begin errors++; $display("FAIL reset_pred_taken got=%0b exp=0", PredTakenF); end
    checks++; if (PredNextPCF !== 32'h104) begin errors++; $display("FAIL reset_next_pc got=%h exp=00000104", PredNextPCF); end
    checks++; if (BranchCnt !== 32'd0) begin errors++; $display("FAIL reset_branch_cnt got=%0d exp=0", BranchCnt); end
    checks++; if (MissCnt !== 32'd0) begin errors++; $display("FAIL reset_miss_cnt got=%0d exp=0", MissCnt); end
  endtask

  task automatic test_first_taken();
    set_ex(32'h100, 3'd1, 1'b1, 32'h80);
    #1;
    checks++; if (MispredictE !== 1'b1) begin errors++; $display("FAIL first_mispredict got=%0b exp=1", MispredictE); end
    checks++; if (RedirectPCE !== 32'h80) begin errors++; $display("FAIL first_redirect got=%h exp=00000080", RedirectPCE); end
    tick();
    idle_ex(); PCF = 32'h100;
    #1;
    checks++; if (PredTakenF !== 1'b1) begin errors++; $display("FAIL first_learned_taken got=%0b exp=1", PredTakenF); end
    checks++; if (PredNextPCF !== 32'h80) begin errors++; $display("FAIL first_learned_target got=%h exp=00000080", PredNextPCF); end
    checks++; if (BranchCnt !== 32'd1) begin errors++; $display("FAIL first_branch_cnt got=%0d exp=1", BranchCnt); end
    checks++; if (MissCnt !== 32'd1) begin errors++; $display("FAIL first_miss_cnt got=%0d exp=1", MissCnt); end
  endtask

  task automatic test_saturate();
    logic [31:0] miss0;
    miss0 = MissCnt;
    for (int k = 0; k < 3; k++) begin
      set_ex(32'h100, 3'd1, 1'b0, 32'h80);
      #1;
      checks++; if (MispredictE !== (k == 0)) begin errors++; $display("FAIL sat_nt_mispredict_%0d got=%0b exp=%0b", k, MispredictE, (k == 0)); end
      tick();
      idle_ex(); PCF = 32'h100;
      #1;
      checks++; if (PredTakenF !== 1'b0) begin errors++; $display("FAIL sat_nt_pred_%0d got=%0b exp=0", k, PredTakenF); end
      checks++; if (MissCnt !== miss0 + 32'd1) begin errors++; $display("FAIL sat_nt_miss_cnt_%0d got=%0d exp=%0d", k, MissCnt, miss0 + 32'd1); end
    end
    // Counter sits at strong-NT: one taken gives weak-NT, a second gives weak-T.
    for (int k = 0; k < 2; k++) begin
      set_ex(32'h100, 3'd1, 1'b1, 32'h80);
      tick();
      idle_ex(); PCF = 32'h100;
      #1;
      checks++; if (PredTakenF !== (k == 1)) begin errors++; $display("FAIL sat_recover_pred_%0d got=%0b exp=%0b", k, PredTakenF, (k == 1)); end
    end
  endtask

  task automatic test_alias();
    set_ex(32'h140, 3'd1, 1'b1, 32'h300);
    #1;
    checks++; if (MispredictE !== 1'b1) begin errors++; $display("FAIL alias_mispredict got=%0b exp=1", MispredictE); end
    tick();
    idle_ex(); PCF = 32'h100;
    #1;
    checks++; if (PredTakenF !== 1'b0) begin errors++; $display("FAIL alias_old_pred got=%0b exp=0", PredTakenF); end
    checks++; if (PredNextPCF !== 32'h104) begin errors++; $display("FAIL alias_old_next got=%h exp=00000104", PredNextPCF); end
    PCF = 32'h140;
    #1;
    checks++; if (PredTakenF !== 1'b1) begin errors++; $display("FAIL alias_new_pred got=%0b exp=1", PredTakenF); end
    checks++; if (PredNextPCF !== 32'h300) begin errors++; $display("FAIL alias_new_next got=%h exp=00000300", PredNextPCF); end
  endtask

  task automatic test_stale_nonbranch();
    idle_ex();
    PCE = 32'h140; PredTakenE = 1'b1; PredTargetE = 32'h300;
    #1;
    checks++; if (MispredictE !== 1'b1) begin errors++; $display("FAIL stale_mispredict got=%0b exp=1", MispredictE); end
    checks++; if (RedirectPCE !== 32'h144) begin errors++; $display("FAIL stale_redirect got=%h exp=00000144", RedirectPCE); end
    tick();
    idle_ex(); PCF = 32'h140;
    #1;
    checks++; if (PredTakenF !== 1'b0) begin errors++; $display("FAIL stale_invalidated got=%0b exp=0", PredTakenF); end
  endtask

  task automatic test_stall();
    logic [31:0] b0, m0;
    b0 = BranchCnt; m0 = MissCnt;
    set_ex(32'h1A4, 3'd2, 1'b1, 32'h40);
    StallE = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (MispredictE !== 1'b0) begin errors++; $display("FAIL stall_mispredict_%0d got=%0b exp=0", k, MispredictE); end
      tick();
    end
    checks++; if (BranchCnt !== b0) begin errors++; $display("FAIL stall_branch_cnt_held got=%0d exp=%0d", BranchCnt, b0); end
    StallE = 1'b0;
    #1;
    checks++; if (MispredictE !== 1'b1) begin errors++; $display("FAIL stall_release_mispredict got=%0b exp=1", MispredictE); end
    tick();
    idle_ex();
    #1;
    checks++; if (BranchCnt !== b0 + 32'd1) begin errors++; $display("FAIL stall_branch_cnt got=%0d exp=%0d", BranchCnt, b0 + 32'd1); end
    checks++; if (MissCnt !== m0 + 32'd1) begin errors++; $display("FAIL stall_miss_cnt got=%0d exp=%0d", MissCnt, m0 + 32'd1); end
  endtask

  function automatic logic [31:0] pick_pc();
    logic [31:0] base;
    base = ($urandom_range(0, 1) == 0) ? 32'h1000 : 32'h2040;
    return base + ($urandom_range(0, 15) << 2);
  endfunction

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst           = ($urandom_range(0, 99) < 2);
      PCF           = pick_pc();
      PCE           = pick_pc();
      BranchTypeE   = ($urandom_range(0, 3) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
      BranchE       = 1'($urandom_range(0, 1));
      BranchTargetE = 32'h3000 + ($urandom_range(0, 7) << 2);
      StallE        = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 3) == 0) begin
        PredTakenE  = 1'($urandom_range(0, 1));
        PredTargetE = 32'h3000 + ($urandom_range(0, 7) << 2);
      end else begin
        PredTakenE  = m_taken(PCE);
        PredTargetE = m_next(PCE);
      end
      #1;
      checks++; if (PredTakenF !== m_taken(PCF)) begin errors++; $display("FAIL rnd_pred_taken n=%0d got=%0b exp=%0b", n, PredTakenF, m_taken(PCF)); end
      checks++; if (PredNextPCF !== m_next(PCF)) begin errors++; $display("FAIL rnd_next_pc n=%0d got=%h exp=%h", n, PredNextPCF, m_next(PCF)); end
      checks++; if (MispredictE !== m_mispredict()) begin errors++; $display("FAIL rnd_mispredict n=%0d got=%0b exp=%0b", n, MispredictE, m_mispredict()); end
      checks++; if (RedirectPCE !== (BranchE ? BranchTargetE : PCE + 32'd4)) begin errors++; $display("FAIL rnd_redirect n=%0d got=%h exp=%h", n, RedirectPCE, (BranchE ? BranchTargetE : PCE + 32'd4)); end
      checks++; if (BranchCnt !== m_bcnt) begin errors++; $display("FAIL rnd_branch_cnt n=%0d got=%0d exp=%0d", n, BranchCnt, m_bcnt); end
      checks++; if (MissCnt !== m_mcnt) begin errors++; $display("FAIL rnd_miss_cnt n=%0d got=%0d exp=%0d", n, MissCnt, m_mcnt); end
      tick();
    end
    rst = 1'b0;
    idle_ex();
  endtask

  task automatic test_reset_mid();
    set_ex(32'h100, 3'd1, 1'b1, 32'h500); tick();
    set_ex(32'h100, 3'd1, 1'b1, 32'h500); tick();
    idle_ex(); PCF = 32'h100;
    #1;
    checks++; if (PredTakenF !== 1'b1) begin errors++; $display("FAIL midrst_trained_pred got=%0b exp=1", PredTakenF); end
    checks++; if (PredNextPCF !== 32'h500) begin errors++; $display("FAIL midrst_trained_next got=%h exp=00000500", PredNextPCF); end
    rst = 1'b1;
    set_ex(32'h100, 3'd1, 1'b0, 32'h500);
    #1;
    checks++; if (MispredictE !== 1'b0) begin errors++; $display("FAIL midrst_mispredict got=%0b exp=0", MispredictE); end
    tick();
    rst = 1'b0; idle_ex(); PCF = 32'h100;
    #1;
    checks++; if (PredTakenF !== 1'b0) begin errors++; $display("FAIL midrst_pred got=%0b exp=0", PredTakenF); end
    checks++; if (PredNextPCF !== 32'h104) begin errors++; $display("FAIL midrst_next got=%h exp=00000104", PredNextPCF); end
    checks++; if (BranchCnt !== 32'd0) begin errors++; $display("FAIL midrst_branch_cnt got=%0d exp=0", BranchCnt); end
    checks++; if (MissCnt !== 32'd0) begin errors++; $display("FAIL midrst_miss_cnt got=%0d exp=0", MissCnt); end
  endtask

  initial begin
    rst = 1'b1; PCF = 32'h0; idle_ex();
    test_reset();
    test_first_taken();
    test_saturate();
    test_alias();
    test_stale_nonbranch();
    test_stall();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
